// File: rtl/jogo_sequencias_param.sv
// Sequence-memory game engine: LFSR-generated sequence, LED playback, timed player-input checking.
// Optional macro JOGO_SYNC_EN inserts a 2-flop synchroniser on botoes ahead of move detection.
module jogo_sequencias_param #(
  parameter int          N_BOTOES   = 4,
  parameter int          PROF_MAX   = 16,
  parameter int          PROF_CURTA = 4,
  parameter int          T_EXIBE    = 1000,
  parameter int          T_PAUSA    = 500,
  parameter int          T_TIMEOUT  = 3000,
  parameter logic [15:0] SEMENTE    = 16'hACE1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                jogar,
  input  logic                modo,
  input  logic [N_BOTOES-1:0] botoes,
  output logic [N_BOTOES-1:0] leds,
  output logic                pronto,
  output logic                ganhou,
  output logic                perdeu,
  output logic                timeout,
  output logic [6:0]          db_rodada,
  output logic [3:0]          db_esperada,
  output logic [3:0]          db_estado
);

  localparam int EW    = $clog2(N_BOTOES);
  localparam int AW    = $clog2(PROF_MAX);
  localparam int T_MAX = (T_EXIBE > T_PAUSA) ? ((T_EXIBE > T_TIMEOUT) ? T_EXIBE : T_TIMEOUT)
                                             : ((T_PAUSA > T_TIMEOUT) ? T_PAUSA : T_TIMEOUT);
  localparam int TW    = $clog2(T_MAX + 1);

  typedef enum logic [3:0] {
    ST_INICIAL = 4'h0, ST_GERA   = 4'h1, ST_PREP    = 4'h2, ST_EXIBE   = 4'h3,
    ST_PAUSA   = 4'h4, ST_ESPERA = 4'h5, ST_COMPARA = 4'h6, ST_GANHOU  = 4'hA,
    ST_PERDEU  = 4'hB, ST_TIMEOUT = 4'hC
  } estado_t;

  estado_t             estado, estado_prox;
  logic [15:0]         lfsr;
  logic [EW-1:0]       mem [PROF_MAX];
  logic [AW-1:0]       addr, addr_d;
  logic [6:0]          rodada, rodada_d, limite, limite_d;
  logic [TW-1:0]       timer, timer_d;
  logic [N_BOTOES-1:0] jogada, jogada_d, botoes_ant, botoes_s, esperado_oh;
  logic                gravar, movimento, ultimo;

`ifdef JOGO_SYNC_EN
  logic [N_BOTOES-1:0] sinc_1, sinc_2;
  always_ff @(posedge clock) begin
    if (reset) begin
      sinc_1 <= '0;
      sinc_2 <= '0;
    end else begin
      sinc_1 <= botoes;
      sinc_2 <= sinc_1;
    end
  end
  assign botoes_s = sinc_2;
`else
  assign botoes_s = botoes;
`endif

  // A move is only the 0 -> nonzero transition; a held button never repeats.
  assign movimento = (botoes_s != '0) && (botoes_ant == '0);
  assign ultimo    = ({{(7-AW){1'b0}}, addr} == (rodada - 7'd1));

  always_comb begin
    esperado_oh = '0;
    esperado_oh[mem[addr]] = 1'b1;
  end

  always_comb begin
    estado_prox = estado;
    addr_d      = addr;
    rodada_d    = rodada;
    limite_d    = limite;
    timer_d     = timer + TW'(1);
    jogada_d    = jogada;
    gravar      = 1'b0;
    case (estado)
      ST_INICIAL, ST_GANHOU, ST_PERDEU, ST_TIMEOUT: begin
        if (jogar) begin
          limite_d    = modo ? 7'(PROF_MAX) : 7'(PROF_CURTA);
          addr_d      = '0;
          rodada_d    = 7'd1;
          estado_prox = ST_GERA;
        end
      end
      ST_GERA: begin
        gravar = 1'b1;
        if (addr == AW'(PROF_MAX - 1)) estado_prox = ST_PREP;
        else                           addr_d      = addr + AW'(1);
      end
      ST_PREP: begin
        addr_d      = '0;
        timer_d     = '0;
        estado_prox = ST_EXIBE;
      end
      ST_EXIBE: begin
        if (timer == TW'(T_EXIBE - 1)) begin
          timer_d     = '0;
          estado_prox = ST_PAUSA;
        end
      end
      ST_PAUSA: begin
        if (timer == TW'(T_PAUSA - 1)) begin
          timer_d = '0;
          if (ultimo) begin
            addr_d      = '0;
            estado_prox = ST_ESPERA;
          end else begin
            addr_d      = addr + AW'(1);
            estado_prox = ST_EXIBE;
          end
        end
      end
      ST_ESPERA: begin
        // A move in the expiry cycle still counts.
        if (movimento) begin
          jogada_d    = botoes_s;
          estado_prox = ST_COMPARA;
        end else if (timer == TW'(T_TIMEOUT - 1)) begin
          estado_prox = ST_TIMEOUT;
        end
      end
      ST_COMPARA: begin
        timer_d = '0;
        if (jogada != esperado_oh) begin
          estado_prox = ST_PERDEU;
        end else if (!ultimo) begin
          addr_d      = addr + AW'(1);
          estado_prox = ST_ESPERA;
        end else if (rodada == limite) begin
          estado_prox = ST_GANHOU;
        end else begin
          rodada_d    = rodada + 7'd1;
          estado_prox = ST_PREP;
        end
      end
      default: estado_prox = ST_INICIAL;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado     <= ST_INICIAL;
      lfsr       <= SEMENTE;
      addr       <= '0;
      rodada     <= '0;
      limite     <= '0;
      timer      <= '0;
      jogada     <= '0;
      botoes_ant <= '0;
      for (int i = 0; i < PROF_MAX; i++) mem[i] <= '0;
    end else begin
      estado     <= estado_prox;
      lfsr       <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      addr       <= addr_d;
      rodada     <= rodada_d;
      limite     <= limite_d;
      timer      <= timer_d;
      jogada     <= jogada_d;
      botoes_ant <= botoes_s;
      if (gravar) mem[addr] <= lfsr[EW-1:0];
    end
  end

  always_comb begin
    leds = '0;
    case (estado)
      ST_EXIBE:  leds = esperado_oh;
      ST_ESPERA: leds = botoes_s;
      default:   leds = '0;
    endcase
  end

  assign ganhou      = (estado == ST_GANHOU);
  assign perdeu      = (estado == ST_PERDEU);
  assign timeout     = (estado == ST_TIMEOUT);
  assign pronto      = ganhou || perdeu || timeout;
  assign db_rodada   = (estado == ST_INICIAL) ? 7'd0 : rodada;
  assign db_esperada = 4'(mem[addr]);
  assign db_estado   = estado;

endmodule
